// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction/data memory responder with a
// fixed-latency request pipeline feeding a 4-entry response FIFO.
// Requests are accepted on a valid/ready handshake, and responses return
// in acceptance order.
// BASE_ADDR is expected to be word aligned.
// Optional feature: define IMEM_RESPONDER_TRACE_EN to print every response
// transfer. The default build has no trace logic.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h01000000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          PIPE_N  = 3;
    localparam int          LAST    = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

    typedef struct packed {
`ifdef IMEM_RESPONDER_TRACE_EN
        logic [31:0] addr;
`endif
        logic        err;
        logic [31:0] data;
    } entry_t;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [29:0]      offsetWord;
    logic [IDX_W-1:0] wordIdx;
    logic             addrErr;
    logic             accept;
    logic             pop;
    entry_t           newEntry;

    logic             pushValid;
    entry_t           pushEntry;

    logic [PIPE_N-1:0] pipeValid_q;
    entry_t            pipeEntry_q [PIPE_N];

    entry_t           fifo_q [4];
    logic [1:0]       wrPtr_q;
    logic [1:0]       rdPtr_q;
    logic [2:0]       fifoCount_q;
    logic [2:0]       fifoCount_d;
    logic [2:0]       outstanding_q;
    logic [2:0]       outstanding_d;
    entry_t           head;

    assign accept     = req_valid && req_ready;
    assign resp_valid = (fifoCount_q != 3'd0);
    assign pop        = resp_valid && resp_ready;
    assign head       = fifo_q[rdPtr_q];
    assign resp_data  = resp_valid ? head.data : 32'd0;
    assign resp_err   = resp_valid && head.err;
    assign req_ready  = reset && (outstanding_q < 3'd4);

    // Decode the request address and build the response for this request.
    always_comb begin
        offsetWord = req_addr[31:2] - BASE_ADDR[31:2];
        wordIdx    = offsetWord[IDX_W-1:0];
        addrErr    = (req_addr[1:0] != 2'b00)
                  || (req_addr < BASE_ADDR)
                  || ({2'b00, offsetWord} >= DEPTH32);
        newEntry      = '0;
        newEntry.err  = addrErr;
        if (!addrErr) begin
            newEntry.data = req_write ? req_wdata : mem[wordIdx];
        end
`ifdef IMEM_RESPONDER_TRACE_EN
        newEntry.addr = req_addr;
`endif
    end

    // Pick what enters the FIFO this edge: the new request for single-cycle
    // latency, otherwise whatever leaves the last used pipeline stage.
    always_comb begin
        pushValid = 1'b0;
        pushEntry = '0;
        if (LATENCY == 1) begin
            pushValid = accept;
            pushEntry = newEntry;
        end else begin
            pushValid = pipeValid_q[LAST];
            pushEntry = pipeEntry_q[LAST];
        end
    end

    // Storage is written at the acceptance edge and is never cleared by reset.
    always_ff @(posedge clock) begin
        if (accept && req_write && !addrErr) begin
            mem[wordIdx] <= req_wdata;
        end
    end

    // Delay line that holds accepted responses until their latency expires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipeValid_q <= '0;
            for (int i = 0; i < PIPE_N; i++) begin
                pipeEntry_q[i] <= '0;
            end
        end else begin
            pipeValid_q[0] <= accept;
            pipeEntry_q[0] <= newEntry;
            for (int i = 1; i < PIPE_N; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeEntry_q[i] <= pipeEntry_q[i-1];
            end
        end
    end

    // Occupancy bookkeeping: a push and a pop on one edge cancel out.
    always_comb begin
        fifoCount_d   = fifoCount_q;
        outstanding_d = outstanding_q;
        if (pushValid && !pop) begin
            fifoCount_d = fifoCount_q + 3'd1;
        end else if (!pushValid && pop) begin
            fifoCount_d = fifoCount_q - 3'd1;
        end
        if (accept && !pop) begin
            outstanding_d = outstanding_q + 3'd1;
        end else if (!accept && pop) begin
            outstanding_d = outstanding_q - 3'd1;
        end
    end

    // Response FIFO storage and pointers; never overflows because the
    // outstanding limit covers pipeline and FIFO together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            fifoCount_q   <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (pushValid) begin
                fifo_q[wrPtr_q] <= pushEntry;
                wrPtr_q         <= wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            fifoCount_q   <= fifoCount_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef IMEM_RESPONDER_TRACE_EN
    // Print each response as it is handed to the initiator.
    always_ff @(posedge clock) begin
        if (reset && pop) begin
            $display("ADDR = %h  DATA = %h  ERR = %0d", head.addr, resp_data, resp_err);
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: directed scenarios plus randomized traffic,
// checked by a queue scoreboard fed from a behavioural memory model.
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h01000000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;

    imem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acceptCycle;
        bit          exact;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] modelMem [int];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    int          acceptCount = 0;
    int          popCount = 0;
    int          lastPopCycle = 0;
    bit          exactMode = 1'b0;

    exp_t        newExp;
    logic [31:0] mData;
    logic        mErr;
    int          popEdge;

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model: flat word array, error when misaligned or outside the window.
    function automatic void model(input logic [31:0] addr, input logic w, input logic [31:0] wd,
                                  output logic [31:0] d, output logic e);
        longint a;
        longint lo;
        longint hi;
        int     idx;
        a   = longint'(addr);
        lo  = longint'(BASE);
        hi  = lo + 4 * DEPTH;
        e   = (a % 4 != 0) || (a < lo) || (a >= hi);
        idx = e ? 0 : int'((a - lo) / 4);
        d   = 32'd0;
        if (!e) begin
            if (w) begin
                modelMem[idx] = wd;
                d = wd;
            end else if (modelMem.exists(idx)) begin
                d = modelMem[idx];
            end
        end
    endfunction

    // Monitor and scoreboard: samples mid-cycle, checks the head response
    // whenever one is presented, and records newly accepted requests.
    always @(negedge clock) begin
        if (reset) begin
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_response: got data %h err %b, expected no response", resp_data, resp_err);
                end else begin
                    checkOutput("resp_data", resp_data, expQ[0].data);
                    checkOutput("resp_err", {31'd0, resp_err}, {31'd0, expQ[0].err});
                    if (resp_ready) begin
                        popEdge = cycle + 1;
                        if (expQ[0].exact) begin
                            checkOutput("latency", 32'(popEdge - expQ[0].acceptCycle), 32'(LAT));
                        end else begin
                            compared++;
                            if (popEdge - expQ[0].acceptCycle < LAT) begin
                                mismatched++;
                                $display("[TB] FAIL min_latency: got %0d, expected >= %0d", popEdge - expQ[0].acceptCycle, LAT);
                            end
                        end
                        void'(expQ.pop_front());
                        popCount++;
                        lastPopCycle = popEdge;
                    end
                end
            end
            if (req_valid && req_ready) begin
                model(req_addr, req_write, req_wdata, mData, mErr);
                newExp.data        = mData;
                newExp.err         = mErr;
                newExp.acceptCycle = cycle + 1;
                newExp.exact       = exactMode;
                expQ.push_back(newExp);
                acceptCount++;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain(input int maxCycles);
        int n;
        n = 0;
        req_valid = 1'b0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(posedge clock);
            #1;
            n++;
        end
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
        end
    endtask

    function automatic logic [31:0] poolAddr(input int k);
        int w;
        w = (k < 8) ? k : DEPTH - 16 + k;
        return BASE + 32'(4 * w);
    endfunction

    initial begin
        int startCycle;
        int a0;
        int p0;
        int r;
        logic [31:0] addr;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_resp_data", resp_data, 32'd0);
        checkOutput("reset_resp_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Write then read back, exact latency
        resp_ready = 1'b1;
        exactMode  = 1'b1;
        applyStimulus(1'b1, 1'b1, BASE, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, BASE, 32'd0);
        drain(20);

        // Fill the pool of known words at both ends of the window
        for (int k = 1; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, poolAddr(k), $urandom);
        end
        drain(20);

        // Error cases: misaligned, below base, one past the end
        applyStimulus(1'b1, 1'b0, BASE + 32'd2, 32'd0);
        applyStimulus(1'b1, 1'b0, BASE - 32'd4, 32'd0);
        applyStimulus(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'd0);
        drain(20);

        // Streaming 8 consecutive reads: one per cycle, no bubbles
        startCycle = cycle + 1;
        p0 = popCount;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, BASE + 32'(4 * k), 32'd0);
        end
        drain(20);
        checkOutput("stream_pops", 32'(popCount - p0), 32'd8);
        checkOutput("stream_span", 32'(lastPopCycle - startCycle), 32'(7 + LAT));

        // Backpressure: 6 offered, 4 accepted
        exactMode  = 1'b0;
        resp_ready = 1'b0;
        a0 = acceptCount;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, BASE + 32'(4 * k), 32'd0);
        end
        req_valid = 1'b0;
        checkOutput("bp_accepted", 32'(acceptCount - a0), 32'd4);
        checkOutput("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("bp_ready_after_pop", {31'd0, req_ready}, 32'd1);
        drain(20);

        // Reset with three requests outstanding
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, BASE + 32'(4 * k), 32'd0);
        end
        req_valid = 1'b0;
        reset = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midreset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        resp_ready = 1'b1;
        p0 = popCount;
        idle(6);
        checkOutput("no_stale_after_reset", 32'(popCount - p0), 32'd0);
        exactMode = 1'b1;
        applyStimulus(1'b1, 1'b0, BASE, 32'd0);
        applyStimulus(1'b1, 1'b0, poolAddr(12), 32'd0);
        drain(20);

        // Randomized traffic with random backpressure and error addresses
        exactMode = 1'b0;
        for (int n = 0; n < 400; n++) begin
            resp_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                addr = poolAddr($urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            end else if (r == 1) begin
                addr = BASE - 32'(4 * $urandom_range(1, 8));
            end else if (r == 2) begin
                addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
            end else begin
                addr = poolAddr($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, addr, $urandom);
        end
        resp_ready = 1'b1;
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001: Parameter BASE_ADDR, default 32'h01000000, byte address of word 0.
REQ-002: Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-003: Parameter LATENCY, default 2, legal range 1..4; cycles from request acceptance to earliest response.
REQ-004: clock  input  1  single clock; all state updates on rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset.
REQ-006: req_valid  input  1  initiator presents a request.
REQ-007: req_ready  output  1  responder can accept a request this cycle.
REQ-008: req_addr  input  32  byte address of request.
REQ-009: req_write  input  1  1 = write, 0 = read.
REQ-010: req_wdata  input  32  write data.
REQ-011: resp_valid  output  1  response word available.
REQ-012: resp_ready  input  1  initiator consumes the response.
REQ-013: resp_data  output  32  read data, or written data for a write.
REQ-014: resp_err  output  1  request was misaligned or out of range.

Function
REQ-015: A request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-016: A response is transferred on a rising edge where resp_valid and resp_ready are both 1.
REQ-017: Every accepted request produces exactly one response, in acceptance order.
REQ-018: Word index = (req_addr - BASE_ADDR) >> 2.
REQ-019: A request is an error when req_addr[1:0] != 0, req_addr < BASE_ADDR, or index >= DEPTH_WORDS.
REQ-020: An error response returns resp_err=1 and resp_data=0.
REQ-021: An error write leaves storage unchanged.
REQ-022: A valid write updates storage at the acceptance edge and returns resp_data=req_wdata with resp_err=0.
REQ-023: A valid read samples storage at the acceptance edge, so a read accepted after a write to the same word returns the new data.
REQ-024: A request accepted at edge N lands in a 4-entry response FIFO at edge N+LATENCY-1; resp_valid is high from edge N+LATENCY-1 when no older response is pending.
REQ-025: The outstanding count is the number of in-flight pipeline entries plus FIFO entries, with a maximum of 4.
REQ-026: req_ready = (outstanding < 4), driven combinationally from registered state.
REQ-027: An accept and a pop on the same edge leave the outstanding count unchanged.
REQ-028: While resp_valid=1 and resp_ready=0, resp_data and resp_err hold stable; the pipeline keeps advancing into FIFO.
REQ-029: With resp_ready held high and a request every cycle, throughput is one request per cycle.

Reset
REQ-030: While reset=0: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, pipeline and FIFO empty, outstanding count=0.
REQ-031: Reset asserted mid-operation discards all in-flight and queued responses immediately; none are delivered after release.
REQ-032: Storage contents are not cleared by reset.
REQ-033: req_ready=1 in the first cycle after reset is released.

Configuration
REQ-034: Macro IMEM_RESPONDER_TRACE_EN defined: on each response transfer, $display prints "ADDR = <addr hex>  DATA = <resp_data hex>  ERR = <resp_err>".
REQ-035: Macro IMEM_RESPONDER_TRACE_EN undefined: no display output and no trace-only logic; all other behaviour is identical.

Verification
REQ-036: Write 32'hDEADBEEF to 32'h01000000, then read the same address, resp_ready=1 -> read response 32'hDEADBEEF, resp_err=0, arriving LATENCY cycles after acceptance.
REQ-037: Read 32'h01000002, then read 32'h00FFFFFC, then read BASE_ADDR+4*DEPTH_WORDS -> three responses with resp_err=1, resp_data=0.
REQ-038: Hold resp_ready=0 and issue 6 back-to-back reads -> exactly 4 accepted, req_ready=0 afterwards; raising resp_ready returns the 4 responses in order, and req_ready reasserts on the first pop.
REQ-039: Streaming reads of 8 consecutive words, resp_ready=1 -> one response per cycle, in order, with no bubbles after the initial LATENCY.
REQ-040: Assert reset with 3 requests outstanding -> resp_valid drops immediately, no stale response after release, and previously written storage data is still readable.
